// File: rtl/irq_sched_pkg.sv
// Shared types, id constants and id-to-line decode for the interrupt request scheduler.
package irq_sched_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DELAY  = 2'd1,
        ST_ASSERT = 2'd2,
        ST_GAP    = 2'd3
    } sched_state_e;

    typedef struct packed {
        logic [4:0] id;
        logic [7:0] delay;
    } irq_req_t;

    localparam logic [4:0] ID_SOFTWARE  = 5'd3;
    localparam logic [4:0] ID_TIMER     = 5'd7;
    localparam logic [4:0] ID_EXTERNAL  = 5'd11;
    localparam logic [4:0] ID_FAST_BASE = 5'd16;
    localparam logic [4:0] ID_NM        = 5'd31;

    localparam int NUM_FAST       = 15;
    localparam int NUM_LINES      = 19;
    localparam int LINE_SOFTWARE  = 0;
    localparam int LINE_TIMER     = 1;
    localparam int LINE_EXTERNAL  = 2;
    localparam int LINE_FAST_BASE = 3;
    localparam int LINE_NM        = 18;

    // One-hot line vector for a legal id, all zeros for an illegal one.
    function automatic logic [NUM_LINES-1:0] id_to_lines(input logic [4:0] id);
        logic [NUM_LINES-1:0] lines;
        logic [4:0]           shamt;
        lines = '0;
        shamt = id - ID_FAST_BASE + 5'(LINE_FAST_BASE);
        if (id == ID_SOFTWARE) begin
            lines[LINE_SOFTWARE] = 1'b1;
        end else if (id == ID_TIMER) begin
            lines[LINE_TIMER] = 1'b1;
        end else if (id == ID_EXTERNAL) begin
            lines[LINE_EXTERNAL] = 1'b1;
        end else if (id == ID_NM) begin
            lines[LINE_NM] = 1'b1;
        end else if (id >= ID_FAST_BASE) begin
            lines = {{(NUM_LINES-1){1'b0}}, 1'b1} << shamt;
        end
        return lines;
    endfunction

    function automatic logic id_is_legal(input logic [4:0] id);
        return |id_to_lines(id);
    endfunction

endpackage

// File: rtl/irq_req_fifo.sv
// Small request FIFO: array storage, head visible on rdata while not empty.
module irq_req_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 13
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_reg [DEPTH];
    logic [AW-1:0]    wr_ptr_reg;
    logic [AW-1:0]    rd_ptr_reg;
    logic [AW:0]      count_reg;
    logic             do_push;
    logic             do_pop;

    assign full    = (count_reg == (AW+1)'(DEPTH));
    assign empty   = (count_reg == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem_reg[rd_ptr_reg];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_reg[wr_ptr_reg] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            // a same-cycle push and pop leave the occupancy unchanged
            case ({do_push, do_pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

endmodule

// File: rtl/irq_req_scheduler.sv
// Queues interrupt requests and replays each one as a delayed, registered irq line
// held until the core acknowledges it or the ack timeout expires.
module irq_req_scheduler
    import irq_sched_pkg::*;
#(
    parameter int FIFO_DEPTH  = 4,
    parameter int ACK_TIMEOUT = 1000
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic [4:0]  req_id_i,
    input  logic [7:0]  req_delay_i,
    input  logic        irq_ack_i,
    input  logic [4:0]  irq_ack_id_i,
    output logic        irq_software_o,
    output logic        irq_timer_o,
    output logic        irq_external_o,
    output logic        irq_nm_o,
    output logic [14:0] irq_fast_o,
    output logic        busy_o,
    output logic        timeout_o,
    output logic        bad_id_o
);

    localparam int TMO_W = $clog2(ACK_TIMEOUT + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(ACK_TIMEOUT - 1);

    sched_state_e         state_reg;
    logic [7:0]           delay_cnt_reg;
    logic [TMO_W-1:0]     tmo_cnt_reg;
    logic [4:0]           id_reg;
    logic [NUM_LINES-1:0] lines_reg;
    logic                 timeout_reg;
    logic                 bad_id_reg;

    irq_req_t fifo_wdata;
    irq_req_t fifo_head;
    logic     fifo_full;
    logic     fifo_empty;
    logic     fifo_pop;
    logic     ack_match;

    assign fifo_wdata = '{id: req_id_i, delay: req_delay_i};
    assign fifo_pop   = (state_reg == ST_IDLE) && !fifo_empty;
    assign ack_match  = irq_ack_i && (irq_ack_id_i == id_reg);

    irq_req_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH ($bits(irq_req_t))
    ) u_fifo (
        .clk   (clk_i),
        .rst_n (rst_ni),
        .push  (req_valid_i),
        .wdata (fifo_wdata),
        .pop   (fifo_pop),
        .rdata (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_reg     <= ST_IDLE;
            delay_cnt_reg <= '0;
            tmo_cnt_reg   <= '0;
            id_reg        <= '0;
            lines_reg     <= '0;
            timeout_reg   <= 1'b0;
            bad_id_reg    <= 1'b0;
        end else begin
            timeout_reg <= 1'b0;
            bad_id_reg  <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (!fifo_empty) begin
                        if (id_is_legal(fifo_head.id)) begin
                            id_reg      <= fifo_head.id;
                            tmo_cnt_reg <= '0;
                            if (fifo_head.delay == 8'd0) begin
                                state_reg <= ST_ASSERT;
                                lines_reg <= id_to_lines(fifo_head.id);
                            end else begin
                                state_reg     <= ST_DELAY;
                                delay_cnt_reg <= fifo_head.delay;
                            end
                        end else begin
                            bad_id_reg <= 1'b1;
                        end
                    end
                end
                ST_DELAY: begin
                    if (delay_cnt_reg == 8'd1) begin
                        state_reg   <= ST_ASSERT;
                        lines_reg   <= id_to_lines(id_reg);
                        tmo_cnt_reg <= '0;
                    end else begin
                        delay_cnt_reg <= delay_cnt_reg - 8'd1;
                    end
                end
                ST_ASSERT: begin
                    // a matching ack wins over a timeout expiring in the same cycle
                    if (ack_match) begin
                        lines_reg <= '0;
                        state_reg <= ST_GAP;
                    end else if (tmo_cnt_reg == TMO_LAST) begin
                        lines_reg   <= '0;
                        timeout_reg <= 1'b1;
                        state_reg   <= ST_GAP;
                    end else begin
                        tmo_cnt_reg <= tmo_cnt_reg + 1'b1;
                    end
                end
                ST_GAP: begin
                    state_reg <= ST_IDLE;
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    assign req_ready_o    = !fifo_full;
    assign busy_o         = (state_reg != ST_IDLE) || !fifo_empty;
    assign timeout_o      = timeout_reg;
    assign bad_id_o       = bad_id_reg;
    assign irq_software_o = lines_reg[LINE_SOFTWARE];
    assign irq_timer_o    = lines_reg[LINE_TIMER];
    assign irq_external_o = lines_reg[LINE_EXTERNAL];
    assign irq_nm_o       = lines_reg[LINE_NM];

    for (genvar gi = 0; gi < NUM_FAST; gi++) begin : g_fast
        assign irq_fast_o[gi] = lines_reg[LINE_FAST_BASE + gi];
    end

endmodule
